// File: rtl/servo_capture_pkg.sv
// Shared types, widths and default timing for the servo pulse capture block.
package servo_capture_pkg;

  localparam int unsigned HI_CNT_W = 10;
  localparam int unsigned TO_CNT_W = 14;
  localparam int unsigned CODE_W   = 8;

  // Defaults sized for a 100 MHz bus_clk
  localparam int unsigned DEF_TICK_CYCLES    = 392;
  localparam int unsigned DEF_OFFSET_TICKS   = 255;
  localparam int unsigned DEF_MIN_HIGH_TICKS = 64;
  localparam int unsigned DEF_MAX_HIGH_TICKS = 767;
  localparam int unsigned DEF_TIMEOUT_TICKS  = 12750;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2
  } cap_state_e;

  // High time in ticks -> servo width code, floored at the offset and clamped to 8 bits
  function automatic logic [CODE_W-1:0] ticks_to_code(
    input logic [HI_CNT_W-1:0] hi,
    input logic [HI_CNT_W-1:0] offset
  );
    logic [HI_CNT_W-1:0] diff;
    diff = '0;
    if (hi <= offset) begin
      return '0;
    end
    diff = hi - offset;
    if (diff >= HI_CNT_W'(255)) begin
      return '1;
    end
    return diff[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/servo_pwm_capture_sync.sv
// Two-flop synchronizer with a registered copy for rise/fall strobes.
module pulse_sync_edge #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Shift the pin through the synchronizer and the edge-detect stage
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Reset to RESET_LEVEL so a reset never fabricates an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      prev_q  <= RESET_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level  = sync2_q;
  assign rise_c = sync2_q & ~prev_q;
  assign fall_c = ~sync2_q & prev_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Measures RC servo pulse high time and presents width codes on a read-stream interface.
module servo_pwm_capture
  import servo_capture_pkg::*;
#(
  parameter int unsigned TICK_CYCLES    = DEF_TICK_CYCLES,
  parameter int unsigned OFFSET_TICKS   = DEF_OFFSET_TICKS,
  parameter int unsigned MIN_HIGH_TICKS = DEF_MIN_HIGH_TICKS,
  parameter int unsigned MAX_HIGH_TICKS = DEF_MAX_HIGH_TICKS,
  parameter int unsigned TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  input  logic              rden,
  output logic [CODE_W-1:0] dout,
  output logic              empty,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              glitch,
  output logic              present
);

  localparam int unsigned          PRESC_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [HI_CNT_W-1:0]  HI_MAX     = HI_CNT_W'(MAX_HIGH_TICKS);
  localparam logic [HI_CNT_W-1:0]  HI_SAT     = HI_CNT_W'(MAX_HIGH_TICKS + 1);
  localparam logic [HI_CNT_W-1:0]  HI_MIN     = HI_CNT_W'(MIN_HIGH_TICKS);
  localparam logic [HI_CNT_W-1:0]  HI_OFFSET  = HI_CNT_W'(OFFSET_TICKS);
  localparam logic [TO_CNT_W-1:0]  TO_LIMIT   = TO_CNT_W'(TIMEOUT_TICKS);
  localparam logic [TO_CNT_W-1:0]  TO_SAT     = '1;

  logic level, rise_c, fall_c;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                tick_c;
  cap_state_e          state_q, state_d;
  logic [HI_CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic                stuck_c;
  logic                capture_c, reject_c, clr_hi_c, count_hi_c;
  logic [CODE_W-1:0]   code_c;
  logic                rd_ok_c, ovr_set_c;

  logic [CODE_W-1:0]   hold_q, hold_d;
  logic                pending_q, pending_d;
  logic [CODE_W-1:0]   dout_q, dout_d;
  logic                overrun_q, overrun_d;
  logic                glitch_q, glitch_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                present_q, present_d;

  // Idle-high reset keeps a pin held high across reset from looking like a fresh rising edge
  pulse_sync_edge #(
    .RESET_LEVEL(1'b1)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(pwm_in),
    .level   (level),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  assign tick_c  = (presc_q == PRESC_LAST);
  assign stuck_c = (hi_cnt_q > HI_MAX);
  assign code_c  = ticks_to_code(hi_cnt_q, HI_OFFSET);
  assign rd_ok_c = rden & pending_q;

  // Tick prescaler, re-phased on every rising edge so quantization is edge-aligned
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if (rise_c || tick_c) begin
      presc_d = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOW: if (!level) state_d = LOW;
      LOW:      if (rise_c) state_d = HIGH;
      HIGH: begin
        if (stuck_c) begin
          state_d = WAIT_LOW;
        end else if (fall_c) begin
          state_d = LOW;
        end
      end
      default:  state_d = WAIT_LOW;
    endcase
  end

  // FSM outputs: counter control and capture/reject strobes
  always_comb begin
    capture_c  = 1'b0;
    reject_c   = 1'b0;
    clr_hi_c   = 1'b0;
    count_hi_c = 1'b0;
    case (state_q)
      LOW: clr_hi_c = rise_c;
      HIGH: begin
        count_hi_c = tick_c;
        if (stuck_c) begin
          reject_c = 1'b1;
        end else if (fall_c) begin
          if (hi_cnt_q < HI_MIN) begin
            reject_c = 1'b1;
          end else begin
            capture_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // High-time counter, saturating one past the stuck limit
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (clr_hi_c) begin
      hi_cnt_d = '0;
    end else if (count_hi_c && (hi_cnt_q != HI_SAT)) begin
      hi_cnt_d = hi_cnt_q + HI_CNT_W'(1);
    end
  end

  // Holding register, read port and sticky overrun
  always_comb begin
    hold_d    = hold_q;
    pending_d = pending_q;
    dout_d    = dout_q;
    overrun_d = overrun_q;
    ovr_set_c = 1'b0;
    if (rd_ok_c) begin
      dout_d    = hold_q;
      pending_d = 1'b0;
    end
    if (capture_c) begin
      hold_d    = code_c;
      pending_d = 1'b1;
      ovr_set_c = pending_q & ~rden;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (ovr_set_c) begin
      overrun_d = 1'b1;
    end
  end

  assign glitch_d = reject_c;

  // Signal-presence watchdog; only accepted pulses refresh it
  always_comb begin
    to_cnt_d  = to_cnt_q;
    present_d = present_q;
    if (capture_c) begin
      to_cnt_d  = '0;
      present_d = 1'b1;
    end else begin
      if (tick_c && (to_cnt_q != TO_SAT)) begin
        to_cnt_d = to_cnt_q + TO_CNT_W'(1);
      end
      if (to_cnt_d >= TO_LIMIT) begin
        present_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      hi_cnt_q  <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      dout_q    <= '0;
      overrun_q <= 1'b0;
      glitch_q  <= 1'b0;
      to_cnt_q  <= '0;
      present_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      hi_cnt_q  <= hi_cnt_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      dout_q    <= dout_d;
      overrun_q <= overrun_d;
      glitch_q  <= glitch_d;
      to_cnt_q  <= to_cnt_d;
      present_q <= present_d;
    end
  end

  assign dout    = dout_q;
  assign empty   = ~pending_q;
  assign overrun = overrun_q;
  assign glitch  = glitch_q;
  assign present = present_q;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Directed and randomized checks of servo_pwm_capture against a pulse-level reference model.
module tb_servo_pwm_capture;

  localparam int TICK   = 2;
  localparam int OFFSET = 255;
  localparam int MINT   = 64;
  localparam int MAXT   = 767;
  localparam int TO     = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic       rden;
  logic       overrun_clr;
  logic [7:0] dout;
  logic       empty;
  logic       overrun;
  logic       glitch;
  logic       present;

  int n_checks = 0;
  int n_fail   = 0;
  int glitch_seen = 0;

  int m_hold, m_dout, m_pending, m_overrun, m_glitches, have_cap, since_cap;

  servo_pwm_capture #(
    .TICK_CYCLES   (TICK),
    .OFFSET_TICKS  (OFFSET),
    .MIN_HIGH_TICKS(MINT),
    .MAX_HIGH_TICKS(MAXT),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .rden       (rden),
    .dout       (dout),
    .empty      (empty),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .glitch     (glitch),
    .present    (present)
  );

  always #5 clk = ~clk;

  // Count every cycle glitch is high, so a stretched pulse shows up as an extra count
  always @(negedge clk) glitch_seen <= glitch_seen + (glitch ? 1 : 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_code(input int t);
    int d;
    d = t - OFFSET;
    if (d < 0) d = 0;
    if (d > 255) d = 255;
    return d;
  endfunction

  function automatic bit ref_reject(input int t);
    return (t < MINT) || (t > MAXT);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_dout = 0; m_pending = 0; m_overrun = 0;
    have_cap = 0; since_cap = 0;
  endtask

  // Effect of one complete pulse of t ticks, optionally with rden during its capture cycle
  task automatic model_pulse(input int t, input bit rd_cap);
    if (ref_reject(t)) begin
      m_glitches++;
      if (rd_cap && m_pending != 0) begin
        m_dout = m_hold;
        m_pending = 0;
      end
    end else begin
      if (m_pending != 0) begin
        if (rd_cap) m_dout = m_hold;
        else m_overrun = 1;
      end
      m_hold = ref_code(t);
      m_pending = 1;
      have_cap = 1;
      since_cap = 0;
    end
  endtask

  task automatic pulse(input int t, input int low, input bit rd_cap);
    pwm_in = 1'b1;
    repeat (t * TICK + 1) @(posedge clk);
    #1 pwm_in = 1'b0;
    since_cap += t * TICK + 1;
    repeat (2) @(posedge clk);
    #1 if (rd_cap) rden = 1'b1;
    @(posedge clk);
    #1 rden = 1'b0;
    model_pulse(t, rd_cap);
    repeat (low - 3) @(posedge clk);
    #1;
    since_cap += low;
  endtask

  task automatic do_read();
    rden = 1'b1;
    @(posedge clk);
    #1 rden = 1'b0;
    if (m_pending != 0) begin
      m_dout = m_hold;
      m_pending = 0;
    end
    since_cap += 1;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    #1;
    chk({tag, ".dout"}, 32'(dout), m_dout);
    chk({tag, ".empty"}, 32'(empty), (m_pending != 0) ? 0 : 1);
    chk({tag, ".overrun"}, 32'(overrun), m_overrun);
    chk({tag, ".glitches"}, glitch_seen, m_glitches);
    if (have_cap == 0) chk({tag, ".present"}, 32'(present), 0);
    else if (since_cap < 5000) chk({tag, ".present"}, 32'(present), 1);
    @(posedge clk);
    #1;
    since_cap += 2;
  endtask

  initial begin
    int t, low;
    bit rc;
    rst = 1'b1; pwm_in = 1'b0; rden = 1'b0; overrun_clr = 1'b0;
    m_glitches = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.dout", 32'(dout), 0);
    chk("reset.empty", 32'(empty), 1);
    chk("reset.overrun", 32'(overrun), 0);
    chk("reset.glitch", 32'(glitch), 0);
    chk("reset.present", 32'(present), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 1.5 ms pulse: empty falls on the third clock after the falling edge
    pwm_in = 1'b1;
    repeat (382 * TICK + 1) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1.empty_before", 32'(empty), 1);
    @(posedge clk);
    @(negedge clk);
    chk("t1.empty_after", 32'(empty), 0);
    chk("t1.present", 32'(present), 1);
    model_pulse(382, 1'b0);
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    do_read();
    check_all("t1_read");

    // 1.0 / 2.0 / 2.5 ms pulses: floor and saturation
    pulse(255, 12, 1'b0); do_read(); check_all("p1ms");
    pulse(510, 12, 1'b0); do_read(); check_all("p2ms");
    pulse(637, 12, 1'b0); do_read(); check_all("p2_5ms");

    // Short glitch, then stuck-high, then a normal pulse
    pulse(25, 12, 1'b0);   check_all("short");
    pulse(1024, 12, 1'b0); check_all("stuck");
    pulse(400, 12, 1'b0);  do_read(); check_all("after_stuck");

    // Boundaries of the accepted range
    pulse(64, 12, 1'b0);  do_read(); check_all("min_ok");
    pulse(63, 12, 1'b0);  check_all("min_rej");
    pulse(767, 12, 1'b0); do_read(); check_all("max_ok");
    pulse(768, 12, 1'b0); check_all("max_rej");

    // Overrun, then clear
    pulse(382, 12, 1'b0);
    pulse(382, 12, 1'b0);
    check_all("ovr_set");
    do_read(); check_all("ovr_read");
    overrun_clr = 1'b1;
    @(posedge clk);
    #1 overrun_clr = 1'b0;
    m_overrun = 0;
    check_all("ovr_clr");

    // rden coincident with the second capture: no overrun, both values readable
    pulse(300, 12, 1'b0);
    pulse(382, 12, 1'b1);
    check_all("coinc_first");
    do_read(); check_all("coinc_second");

    // Reset released mid-pulse: the truncated pulse is never measured
    pwm_in = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid.dout", 32'(dout), 0);
    chk("rst_mid.empty", 32'(empty), 1);
    chk("rst_mid.present", 32'(present), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (400) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_all("rst_mid_after");
    pulse(306, 12, 1'b0); do_read(); check_all("rst_next");

    // Randomized pulses and reads
    for (int i = 0; i < 14; i++) begin
      t   = int'($urandom_range(20, 800));
      low = int'($urandom_range(8, 40));
      rc  = ($urandom_range(0, 3) == 0);
      pulse(t, low, rc);
      check_all("rand_pulse");
      if ($urandom_range(0, 1) == 1) begin
        do_read();
        check_all("rand_read");
      end
    end

    // Timeout: present drops one timeout after the last capture
    do_read();
    overrun_clr = 1'b1;
    @(posedge clk);
    #1 overrun_clr = 1'b0;
    m_overrun = 0;
    pulse(382, 3, 1'b0);
    repeat (TICK * (TO - 1)) @(posedge clk);
    @(negedge clk);
    chk("timeout.before", 32'(present), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("timeout.after", 32'(present), 0);
    @(posedge clk);
    #1;
    do_read();
    @(negedge clk);
    chk("timeout.read", 32'(dout), 127);
    @(posedge clk);
    #1;
    do_read();
    @(negedge clk);
    chk("empty_read.dout", 32'(dout), 127);
    chk("empty_read.empty", 32'(empty), 1);
    chk("final.glitches", glitch_seen, m_glitches);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
